// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared processor encodings for the HI/LO multiply/divide unit
//
// Purpose : holds the Op encodings seen on the register-file side of the
//           multiply/divide unit and the FSM state encoding used inside it.
// Contents: md_op_e    - MULT / MULTU / DIV / DIVU
//           md_state_e - IDLE / RUN / FIX / DONE
//           helpers    - decode of the two Op bits
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // Op[1] selects divide, Op[0] selects the unsigned flavour.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
//
// Purpose : MIPS-style MULT/MULTU/DIV/DIVU engine. One shift-add (multiply)
//           or restoring shift-subtract (divide) step per cycle on operand
//           magnitudes, followed by one sign-fixup cycle that loads HI/LO.
// Ports   : clk        - rising-edge clock
//           reset      - asynchronous active-high reset
//           Start      - begin an operation (accepted in IDLE or DONE only)
//           Op         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//           A, B       - rs / rt operands
//           WriteHI    - MTHI strobe
//           WriteLO    - MTLO strobe
//           WriteData  - MTHI/MTLO data
//           Busy       - high in RUN and FIX (PC stall)
//           Done       - one-cycle completion pulse
//           DivByZero  - qualifies Done for a divide with B = 0
//           HI, LO     - result registers (MFHI/MFLO source)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         WriteHI,
  input  logic         WriteLO,
  input  logic [N-1:0] WriteData,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero,
  output logic [N-1:0] HI,
  output logic [N-1:0] LO
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  md_state_e     state, state_next;
  logic [CW-1:0] count;
  logic [1:0]    op_q;
  logic          sign_a, sign_b;
  logic          dbz_q;
  logic [N-1:0]  mag_b;
  logic [N-1:0]  acc_hi, acc_lo;
  logic [N-1:0]  hi_q, lo_q;

  logic          start_ok;
  logic          div_zero_req;
  logic          write_ok;
  logic          busy_c, done_c;

  // ---------------------------------------------------------------- operand capture
  logic          a_neg, b_neg;
  logic [N-1:0]  a_mag, b_mag;

  always_comb begin
    a_neg        = op_is_signed(Op) & A[N-1];
    b_neg        = op_is_signed(Op) & B[N-1];
    a_mag        = a_neg ? ('0 - A) : A;
    b_mag        = b_neg ? ('0 - B) : B;
    div_zero_req = op_is_div(Op) && (B == '0);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          start_ok   = 1'b1;
          state_next = div_zero_req ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (count == LAST_STEP) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        busy_c     = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done_c = 1'b1;
        if (Start) begin
          start_ok   = 1'b1;
          state_next = div_zero_req ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // MTHI/MTLO only land when idle and no Start claims this edge.
  assign write_ok = ~busy_c & ~start_ok;

  // ---------------------------------------------------------------- step datapath
  // Both operations keep the working value in {acc_hi, acc_lo}, with the
  // dividend / multiplier starting in acc_lo and acc_hi cleared.
  logic [N:0]    mul_sum;
  logic [N-1:0]  mul_hi_next, mul_lo_next;
  logic [N:0]    div_shift, div_diff;
  logic [N-1:0]  div_hi_next, div_lo_next;

  always_comb begin
    // Multiply: add multiplicand into the top half when the current
    // multiplier bit is set, then shift the whole 2N+1-bit value right.
    mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    mul_hi_next = mul_sum[N:1];
    mul_lo_next = {mul_sum[0], acc_lo[N-1:1]};

    // Divide: shift the next dividend bit into the remainder and try the
    // subtraction; a set bit N means the trial went negative, so restore.
    div_shift = {acc_hi, acc_lo[N-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    if (!div_diff[N]) begin
      div_hi_next = div_diff[N-1:0];
      div_lo_next = {acc_lo[N-2:0], 1'b1};
    end else begin
      div_hi_next = div_shift[N-1:0];
      div_lo_next = {acc_lo[N-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------- sign fix-up
  logic            res_neg, rem_neg;
  logic [2*N-1:0]  prod_raw, prod_fix;
  logic [N-1:0]    quo_fix, rem_fix;

  always_comb begin
    res_neg  = op_is_signed(op_q) & (sign_a ^ sign_b);
    rem_neg  = op_is_signed(op_q) & sign_a;
    prod_raw = {acc_hi, acc_lo};
    prod_fix = res_neg ? ('0 - prod_raw) : prod_raw;
    quo_fix  = res_neg ? ('0 - acc_lo) : acc_lo;
    rem_fix  = rem_neg ? ('0 - acc_hi) : acc_hi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dbz_q  <= 1'b0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (start_ok) begin
      count  <= '0;
      op_q   <= Op;
      sign_a <= a_neg;
      sign_b <= b_neg;
      dbz_q  <= div_zero_req;
      mag_b  <= b_mag;
      acc_hi <= '0;
      acc_lo <= a_mag;
    end else if (state == ST_RUN) begin
      count <= count + CW'(1);
      if (op_is_div(op_q)) begin
        acc_hi <= div_hi_next;
        acc_lo <= div_lo_next;
      end else begin
        acc_hi <= mul_hi_next;
        acc_lo <= mul_lo_next;
      end
    end
  end

  // ---------------------------------------------------------------- HI / LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_FIX) begin
      if (op_is_div(op_q)) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end else begin
        hi_q <= prod_fix[2*N-1:N];
        lo_q <= prod_fix[N-1:0];
      end
    end else if (write_ok) begin
      if (WriteHI) hi_q <= WriteData;
      if (WriteLO) lo_q <= WriteData;
    end
  end

  assign Busy      = busy_c;
  assign Done      = done_c;
  assign DivByZero = done_c & dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         Start;
  logic [1:0]   Op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         WriteHI;
  logic         WriteLO;
  logic [N-1:0] WriteData;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [N-1:0] HI;
  logic [N-1:0] LO;

  int n_cmp;
  int n_bad;

  mult_div_unit #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .WriteHI   (WriteHI),
    .WriteLO   (WriteLO),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with Start already driven; returns at the negedge
  // where Done is seen (or when the cycle budget expires).
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (Busy) busy_n++;
      if (lat == 1) begin
        Start   = 1'b0;
        WriteHI = 1'b0;
        WriteLO = 1'b0;
      end
    end while (!Done && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo,
                        input logic exp_dbz);
    int lat, busy_n;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    wait_done(lat, busy_n);
    check_eq({tag, "_lat"},  64'(lat),    exp_dbz ? 64'd1 : 64'(N + 2));
    check_eq({tag, "_busy"}, 64'(busy_n), exp_dbz ? 64'd0 : 64'(N + 1));
    check_eq({tag, "_dbz"},  64'(DivByZero), 64'(exp_dbz));
    check_eq({tag, "_hi"},   64'(HI), 64'(exp_hi));
    check_eq({tag, "_lo"},   64'(LO), 64'(exp_lo));
  endtask

  initial begin
    int lat, busy_n, done_seen;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    Start     = 1'b0;
    Op        = 2'b00;
    A         = '0;
    B         = '0;
    WriteHI   = 1'b0;
    WriteLO   = 1'b0;
    WriteData = '0;

    @(negedge clk);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_dbz",  64'(DivByZero), 64'd0);
    check_eq("rst_hi",   64'(HI), 64'd0);
    check_eq("rst_lo",   64'(LO), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(negedge clk);
    check_eq("after_done", 64'(Done), 64'd0);
    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    @(negedge clk);
    run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    @(negedge clk);

    // MTHI then MTLO, then divide by zero must leave them untouched.
    WriteHI = 1'b1; WriteData = 32'h11;
    @(negedge clk);
    WriteHI = 1'b0; WriteLO = 1'b1; WriteData = 32'h22;
    @(negedge clk);
    WriteLO = 1'b0;
    check_eq("mthi", 64'(HI), 64'h11);
    check_eq("mtlo", 64'(LO), 64'h22);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'h11, 32'h22, 1'b1);
    @(negedge clk);
    check_eq("dbz_clear_done", 64'(Done), 64'd0);
    check_eq("dbz_clear_flag", 64'(DivByZero), 64'd0);

    // MULTU 2x3 with a Start and an MTLO injected mid-RUN.
    Start = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd3;
    lat = 0; busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (Busy) busy_n++;
      if (lat == 1) Start = 1'b0;
      if (lat == 10) begin
        Start = 1'b1; Op = 2'b11; A = 32'd9; B = 32'd2;
        WriteLO = 1'b1; WriteData = 32'h55;
      end
      if (lat == 11) begin
        Start = 1'b0; WriteLO = 1'b0;
        check_eq("run_hold_lo", 64'(LO), 64'h22);
        check_eq("run_hold_hi", 64'(HI), 64'h11);
      end
    end while (!Done && lat < 200);
    check_eq("inj_lat", 64'(lat), 64'(N + 2));
    check_eq("inj_hi",  64'(HI), 64'd0);
    check_eq("inj_lo",  64'(LO), 64'd6);
    // Back-to-back from DONE.
    run_op("divu_b2b", 2'b11, 32'd9, 32'd2, 32'd1, 32'd4, 1'b0);
    @(negedge clk);

    // Both strobes together.
    WriteHI = 1'b1; WriteLO = 1'b1; WriteData = 32'hA5;
    @(negedge clk);
    WriteHI = 1'b0; WriteLO = 1'b0;
    check_eq("mt_both_hi", 64'(HI), 64'hA5);
    check_eq("mt_both_lo", 64'(LO), 64'hA5);

    // Start wins over a simultaneous MTHI.
    Start = 1'b1; Op = 2'b01; A = 32'd1; B = 32'd1;
    WriteHI = 1'b1; WriteData = 32'h77;
    wait_done(lat, busy_n);
    check_eq("prio_lat", 64'(lat), 64'(N + 2));
    check_eq("prio_lo",  64'(LO), 64'd1);
    check_eq("prio_hi",  64'(HI), 64'd0);
    @(negedge clk);
    Start = 1'b1; Op = 2'b01; A = 32'd1; B = 32'd1;
    WriteHI = 1'b1; WriteData = 32'h77;
    @(negedge clk);
    Start = 1'b0; WriteHI = 1'b0;
    check_eq("prio_hold_hi", 64'(HI), 64'd0);
    wait_done(lat, busy_n);
    @(negedge clk);

    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 64'(Busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", 64'(Busy), 64'd0);
    check_eq("mid_rst_done", 64'(Done), 64'd0);
    check_eq("mid_rst_hi",   64'(HI), 64'd0);
    check_eq("mid_rst_lo",   64'(LO), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (N + 10) begin
      @(negedge clk);
      if (Done || Busy) done_seen++;
    end
    check_eq("post_rst_quiet", 64'(done_seen), 64'd0);
    check_eq("post_rst_lo",    64'(LO), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: N, default 32, operand and HI/LO width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to begin an operation; sampled on a rising edge of clk.
REQ-005 Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  N  rs operand from register file ReadData1.
REQ-007 B  input  N  rt operand from register file ReadData2.
REQ-008 WriteHI  input  1  MTHI strobe.
REQ-009 WriteLO  input  1  MTLO strobe.
REQ-010 WriteData  input  N  MTHI/MTLO data.
REQ-011 Busy  output  1  operation in progress; the processor stalls the PC while Busy is high.
REQ-012 Done  output  1  one-cycle completion pulse.
REQ-013 DivByZero  output  1  qualifies Done; high when the completed op was DIV/DIVU with B=0.
REQ-014 HI  output  N  HI register (MFHI source).
REQ-015 LO  output  N  LO register (MFLO source).

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
- Busy=1 only in RUN and FIX.
- Done=1 only in DONE.
REQ-017 Start SHALL be accepted only in IDLE or DONE; Start in RUN or FIX SHALL be ignored.
REQ-018 On an accepted Start, the block SHALL capture Op, |A| and |B| (magnitudes for signed ops, raw values for unsigned ops) and the sign bits, clear the iteration counter, and enter RUN.
- Exception: for a DIV/DIVU with B=0, it SHALL enter DONE directly with DivByZero=1 and HI/LO unchanged.
REQ-019 RUN SHALL perform one radix-2 step per cycle for exactly N cycles, then go to FIX.
- Multiply: shift-add on a 2N-bit product.
- Divide: restoring shift-subtract producing quotient and remainder.
REQ-020 FIX SHALL apply sign correction, load HI/LO, and go to DONE.
- MULT: negate the 2N-bit product if sign(A) XOR sign(B).
- DIV: negate the quotient if sign(A) XOR sign(B); give the remainder the sign of A.
REQ-021 Results SHALL be written as follows:
- Multiply: HI = product[2N-1:N], LO = product[N-1:0].
- Divide: LO = quotient, HI = remainder.
- All arithmetic is modulo 2^N; DIV of -2^(N-1) by -1 SHALL yield LO=0x80000000, HI=0.
REQ-022 Latency: for Start accepted at edge k, Done SHALL be high in the cycle after edge k+N+1 (N+2 cycles) for normal ops, and in the cycle after edge k for divide-by-zero.
REQ-023 DONE SHALL last one cycle, then return to IDLE, or to RUN if Start is asserted in that cycle.
REQ-024 DivByZero SHALL be 0 whenever Done=0.
REQ-025 WriteHI/WriteLO SHALL load WriteData into HI/LO on the next edge only when Busy=0 and no Start is accepted on that edge.
- Writes during Busy SHALL be discarded.
- Start SHALL take priority over a simultaneous write, and the write SHALL be discarded.
- WriteHI and WriteLO together SHALL load both registers.
REQ-026 HI/LO SHALL hold their previous values throughout RUN and FIX.

Reset
REQ-027 Reset SHALL set the following immediately, independent of clk: state=IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, counter=0.
REQ-028 Reset during RUN or FIX SHALL abandon the operation with no HI/LO update after reset release.

Structure
REQ-029 The Op encodings and the FSM state encoding SHALL reside in the shared processor package.
REQ-030 The unit SHALL be a single module with no sub-modules; the step datapath and FSM are local to it.

Verification
REQ-031 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Done exactly N+2 cycles after Start; Busy high for N+1 cycles.
REQ-032 MULT A=-3, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIVU A=7, B=0, with HI/LO preloaded via MTHI=0x11, MTLO=0x22 -> Done and DivByZero high in the cycle after the Start edge; HI=0x11, LO=0x22.
REQ-034 MULTU 2x3 running; Start (DIVU 9/2) and WriteLO=0x55 pulsed mid-RUN -> both ignored; HI=0, LO=6; then back-to-back Start in DONE gives LO=4, HI=1.
REQ-035 Reset asserted mid-RUN -> Busy, Done, HI, LO go to 0 immediately; no Done after release.
REQ-036 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
